// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus arbiter slice.
package hyperbus_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADR_W       = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ISSUE  = 5'b00010,
    S_ACTIVE = 5'b00100,
    S_DRAIN  = 5'b01000,
    S_FAULT  = 5'b10000
  } state_e;

  // Command latched from the winning requester and presented to the controller.
  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat;
    logic              rg;
    logic              we;
  } cmd_t;

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational rotating-priority picker: searches from last+1 upward, wrapping to 0.
module hyperbus_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [LW-1:0]   grant_o,
  output logic            any_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(last_i) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_o && req_i[LW'(idx)]) begin
        any_o   = 1'b1;
        grant_o = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter and single-outstanding transaction sequencer in front of the
// hyperbus controller, with a transaction watchdog and a sticky fault state.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ-1:0]        req_reg,
  input  logic [NREQ*ADR_W-1:0]  req_adr,
  input  logic [NREQ*DATA_W-1:0] req_wdat,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ-1:0]        rsp_err,
  output logic [DATA_W-1:0]      rsp_rdat,
  output logic [ADR_W-1:0]       m_adr,
  output logic [DATA_W-1:0]      m_dat,
  output logic                   m_reg,
  output logic                   m_rrq,
  output logic                   m_wrq,
  input  logic [DATA_W-1:0]      m_dat_o,
  input  logic                   m_dvalid,
  input  logic                   m_dready,
  input  logic                   m_busy,
  input  logic                   m_error,
  output logic                   fault_o
);

  localparam int unsigned LW   = $clog2(NREQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     rspv_q, rspv_d;
  logic [NREQ-1:0]     rspe_q, rspe_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                rrq_q, rrq_d;
  logic                wrq_q, wrq_d;
  logic                fault_q, fault_d;
  logic                pend_q, pend_d;
  logic [LW-1:0]       last_q, last_d;
  logic [LW-1:0]       own_q, own_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [LW-1:0]       win_c;
  logic                any_c;
  logic                abort_c;
  logic                go_fault_c;

  hyperbus_rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (win_c),
    .any_o   (any_c)
  );

  // Watchdog fires on the cycle its count would reach zero.
  assign abort_c = m_error || (wd_q <= WD_W'(1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ack_d      = '0;
    rspv_d     = '0;
    rspe_d     = '0;
    rdat_d     = rdat_q;
    rrq_d      = rrq_q;
    wrq_d      = wrq_q;
    fault_d    = fault_q;
    pend_d     = pend_q;
    last_d     = last_q;
    own_d      = own_q;
    wd_d       = wd_q;
    go_fault_c = 1'b0;

    if ((state_q != S_IDLE) && (state_q != S_FAULT) && (wd_q != '0)) begin
      wd_d = wd_q - WD_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (any_c && !m_busy) begin
          ack_d[win_c] = 1'b1;
          last_d       = win_c;
          own_d        = win_c;
          cmd_d.adr    = req_adr[win_c*ADR_W +: ADR_W];
          cmd_d.dat    = req_wdat[win_c*DATA_W +: DATA_W];
          cmd_d.rg     = req_reg[win_c];
          cmd_d.we     = req_we[win_c];
          rrq_d        = ~req_we[win_c];
          wrq_d        = req_we[win_c];
          wd_d         = WD_W'(TIMEOUT);
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_c) begin
          go_fault_c = 1'b1;
        end else if (m_busy) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (abort_c) begin
          go_fault_c = 1'b1;
        end else if ((!cmd_q.we && m_dvalid) || (cmd_q.we && m_dready)) begin
          rspv_d[own_q] = 1'b1;
          if (!cmd_q.we) begin
            rdat_d = m_dat_o;
          end
          rrq_d   = 1'b0;
          wrq_d   = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_c) begin
          go_fault_c = 1'b1;
        end else if (!m_busy) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        // Fail every request: ack one cycle, error response the next.
        if (pend_q) begin
          rspv_d[own_q] = 1'b1;
          rspe_d[own_q] = 1'b1;
          pend_d        = 1'b0;
        end else if (any_c) begin
          ack_d[win_c] = 1'b1;
          last_d       = win_c;
          own_d        = win_c;
          pend_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_fault_c) begin
      rspv_d[own_q] = 1'b1;
      rspe_d[own_q] = 1'b1;
      rrq_d         = 1'b0;
      wrq_d         = 1'b0;
      fault_d       = 1'b1;
      state_d       = S_FAULT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ack_q   <= '0;
      rspv_q  <= '0;
      rspe_q  <= '0;
      rdat_q  <= '0;
      rrq_q   <= 1'b0;
      wrq_q   <= 1'b0;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= LW'(NREQ - 1);
      own_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      rspv_q  <= rspv_d;
      rspe_q  <= rspe_d;
      rdat_q  <= rdat_d;
      rrq_q   <= rrq_d;
      wrq_q   <= wrq_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      own_q   <= own_d;
      wd_q    <= wd_d;
    end
  end

  assign req_ack   = ack_q;
  assign rsp_valid = rspv_q;
  assign rsp_err   = rspe_q;
  assign rsp_rdat  = rdat_q;
  assign m_adr     = cmd_q.adr;
  assign m_dat     = cmd_q.dat;
  assign m_reg     = cmd_q.rg;
  assign m_rrq     = rrq_q;
  assign m_wrq     = wrq_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scoreboard bench for hyperbus_arbiter with a small behavioural controller model.
module tb_hyperbus_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  req_valid, req_we, req_reg;
  logic [63:0] req_adr;
  logic [31:0] req_wdat;
  logic [1:0]  req_ack, rsp_valid, rsp_err;
  logic [15:0] rsp_rdat;
  logic [31:0] m_adr;
  logic [15:0] m_dat;
  logic        m_reg, m_rrq, m_wrq;
  logic [15:0] m_dat_o;
  logic        m_dvalid, m_dready, m_busy, m_error;
  logic        fault_o;

  hyperbus_arbiter #(.NREQ(2), .TIMEOUT(20)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_reg(req_reg),
    .req_adr(req_adr), .req_wdat(req_wdat),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdat(rsp_rdat),
    .m_adr(m_adr), .m_dat(m_dat), .m_reg(m_reg), .m_rrq(m_rrq), .m_wrq(m_wrq),
    .m_dat_o(m_dat_o), .m_dvalid(m_dvalid), .m_dready(m_dready), .m_busy(m_busy),
    .m_error(m_error), .fault_o(fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        rg;
    logic [31:0] adr;
    logic [15:0] wdat;
    logic        err;
  } req_t;

  req_t q0[$], q1[$], e0[$], e1[$];
  int   ack_exp[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  bit   have_last = 0;
  bit   mdl_err = 0;
  bit   mdl_nobusy = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy one cycle after a command, data/ready two cycles later,
  // busy held two cycles after completion. Error mode raises a sticky m_error instead.
  int   mph, mcnt;
  logic mwr;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_dvalid <= 1'b0; m_dready <= 1'b0; m_error <= 1'b0;
      m_dat_o <= '0; mph <= 0; mcnt <= 0; mwr <= 1'b0;
    end else begin
      m_dvalid <= 1'b0;
      m_dready <= 1'b0;
      case (mph)
        0: if ((m_rrq || m_wrq) && !mdl_nobusy) begin
             m_busy <= 1'b1; mph <= 1; mcnt <= 2; mwr <= m_wrq;
           end
        1: if (mcnt > 0) mcnt <= mcnt - 1;
           else if (mdl_err) begin m_error <= 1'b1; mph <= 3; end
           else begin
             if (mwr) m_dready <= 1'b1;
             else begin m_dvalid <= 1'b1; m_dat_o <= m_adr[15:0] ^ 16'hA54A; end
             mph <= 2; mcnt <= 2;
           end
        2: if (mcnt > 0) mcnt <= mcnt - 1;
           else begin m_busy <= 1'b0; mph <= 0; end
        default: ;
      endcase
    end
  end

  task automatic load_port(input int i);
    req_t r;
    if (i == 0) begin
      if (q0.size() == 0) return;
      r = q0.pop_front(); e0.push_back(r);
    end else begin
      if (q1.size() == 0) return;
      r = q1.pop_front(); e1.push_back(r);
    end
    req_we[i] = r.we; req_reg[i] = r.rg;
    req_adr[32*i +: 32] = r.adr; req_wdat[16*i +: 16] = r.wdat;
    req_valid[i] = 1'b1;
  endtask

  task automatic push_req(input int p, input logic we, input logic rg,
                          input logic [31:0] adr, input logic [15:0] wdat, input logic err);
    req_t r;
    r.we = we; r.rg = rg; r.adr = adr; r.wdat = wdat; r.err = err;
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  // Requester driver plus ack/response scoreboard, on the inactive edge.
  always @(negedge clk) begin : mon
    req_t r;
    int   p;
    int   qs;
    if (rstn) begin
      if (req_ack != 2'b00) begin
        chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
        if (ack_exp.size() == 0) chk("ack_unexpected", 32'(ack_exp.size()), 32'd1);
        else chk("ack_port", 32'(req_ack), 32'd1 << ack_exp.pop_front());
        if (have_last && !fault_o) chk("ack_gap_ge4", 32'((cyc - last_ack_cyc) >= 4), 32'd1);
        have_last = 1; last_ack_cyc = cyc;
      end
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
        p  = rsp_valid[1] ? 1 : 0;
        qs = (p == 0) ? e0.size() : e1.size();
        if (qs == 0) chk("rsp_unexpected", 32'(qs), 32'd1);
        else begin
          r = (p == 0) ? e0.pop_front() : e1.pop_front();
          chk("rsp_err", 32'(rsp_err), r.err ? 32'(rsp_valid) : 32'd0);
          if (!r.we && !r.err) chk("rsp_rdat", 32'(rsp_rdat), 32'(r.adr[15:0] ^ 16'hA54A));
        end
      end else if (rsp_err != 2'b00) begin
        chk("rsp_err_stray", 32'(rsp_err), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ack[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) load_port(i);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ack_rsp"}, 32'({req_ack, rsp_valid, rsp_err}), 32'd0);
    chk({tag, "_rdat_mdat"}, {rsp_rdat, m_dat}, 32'd0);
    chk({tag, "_madr"}, m_adr, 32'd0);
    chk({tag, "_ctl"}, 32'({m_reg, m_rrq, m_wrq, fault_o}), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk_zero(tag);
    q0.delete(); q1.delete(); e0.delete(); e1.delete(); ack_exp.delete();
    req_valid = '0; have_last = 0; mdl_err = 0; mdl_nobusy = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input bit busy_chk);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && e0.size() == 0 && e1.size() == 0 &&
          ack_exp.size() == 0 && req_valid == 2'b00 && (!busy_chk || !m_busy)) done = 1;
    end
    chk(tag, 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string tag, input int which);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      case (which)
        0: done = m_dvalid;
        1: done = m_dready;
        2: done = m_busy;
        default: done = fault_o;
      endcase
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  int t0, t1;

  initial begin
    rstn = 1'b0; req_valid = '0; req_we = '0; req_reg = '0; req_adr = '0; req_wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single read on port 0.
    ack_exp.push_back(0);
    push_req(0, 1'b0, 1'b0, 32'h0000_0010, 16'h0, 1'b0);
    @(posedge clk); #1;
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_rrq", 32'({m_rrq, m_wrq}), 32'h2);
    chk("t1_adr", m_adr, 32'h0000_0010);
    wait_sig("t1_dvalid_seen", 0);
    @(posedge clk); #1;
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rdat", 32'(rsp_rdat), 32'hA55A);
    chk("t1_rrq_low_busy_high", 32'({m_rrq, m_busy}), 32'h1);
    wait_idle("t1_drain", 1);

    // Register write on port 1.
    ack_exp.push_back(1);
    push_req(1, 1'b1, 1'b1, 32'h0000_0020, 16'h1234, 1'b0);
    @(posedge clk); #1;
    chk("t3_ack", 32'(req_ack), 32'h2);
    chk("t3_cmd", 32'({m_wrq, m_rrq, m_reg}), 32'h5);
    chk("t3_mdat", 32'(m_dat), 32'h1234);
    wait_sig("t3_dready_seen", 1);
    @(posedge clk); #1;
    chk("t3_rspv", 32'(rsp_valid), 32'h2);
    wait_idle("t3_drain", 1);

    // Both ports stream reads: strict alternation.
    for (int k = 0; k < 3; k++) begin
      ack_exp.push_back(0); ack_exp.push_back(1);
      push_req(0, 1'b0, 1'b0, 32'h100 + 32'(k * 4), 16'h0, 1'b0);
      push_req(1, 1'b0, 1'b0, 32'h200 + 32'(k * 4), 16'h0, 1'b0);
    end
    wait_idle("t2_drain", 1);

    // Reset in ACTIVE, then port 0 must win a contested grant.
    ack_exp.push_back(0);
    push_req(0, 1'b0, 1'b0, 32'h300, 16'h0, 1'b0);
    wait_sig("t4_busy_seen", 2);
    @(posedge clk); #1;
    chk("t4_cmd_active", 32'(m_rrq), 32'h1);
    do_reset("t4_rst");
    ack_exp.push_back(0); ack_exp.push_back(1);
    push_req(0, 1'b0, 1'b0, 32'h310, 16'h0, 1'b0);
    push_req(1, 1'b0, 1'b0, 32'h320, 16'h0, 1'b0);
    wait_idle("t4_drain", 1);

    // Controller error during ACTIVE, then fault-mode service of port 1.
    mdl_err = 1;
    ack_exp.push_back(0);
    push_req(0, 1'b0, 1'b0, 32'h400, 16'h0, 1'b1);
    wait_sig("t5_fault_seen", 3);
    chk("t5_err_rsp", 32'({rsp_valid, rsp_err}), 32'h5);
    chk("t5_cmd_dropped", 32'({m_rrq, m_wrq}), 32'h0);
    ack_exp.push_back(1);
    push_req(1, 1'b0, 1'b0, 32'h404, 16'h0, 1'b1);
    @(posedge clk); #1;
    chk("t5_fault_ack", 32'(req_ack), 32'h2);
    @(posedge clk); #1;
    chk("t5_fault_rsp", 32'({rsp_valid, rsp_err}), 32'hA);
    chk("t5_fault_cmd", 32'({m_rrq, m_wrq, fault_o}), 32'h1);
    wait_idle("t5_drain", 0);
    do_reset("t5_rst");

    // Watchdog: controller never goes busy.
    mdl_nobusy = 1;
    ack_exp.push_back(0);
    push_req(0, 1'b0, 1'b0, 32'h500, 16'h0, 1'b1);
    t0 = -1000; t1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (req_ack[0]) t0 = cyc;
      if (fault_o) begin t1 = cyc; break; end
    end
    chk("t6_wd_cycles", 32'(t1 - t0), 32'd20);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_fault_sticky", 32'({fault_o, m_rrq}), 32'h2);
    wait_idle("t6_drain", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Round-robin arbiter and transaction sequencer placed in front of the `hyperbus` controller. It lets NREQ independent requesters share one HyperBus device: it latches one request at a time, drives the controller's request pins for the required duration, and routes the completion or error back to the owning port. It also adds a transaction watchdog and a sticky fault state that mirrors the controller's unrecoverable error state.

## Interface
- `NREQ`, 2: number of requester ports (2..8).
- `TIMEOUT`, 255: maximum cycles from issue to drain-complete before a fault.
- `clk`  in  1  memory clock; the same 200 MHz `clk` as the controller.
- `rstn`  in  1  reset; one clock, asynchronous, active-low.
- `req_valid`  in  NREQ  per-port request; held until `req_ack`.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_reg`  in  NREQ  1 = register space.
- `req_adr`  in  NREQ*32  address, port i at [32i+31:32i].
- `req_wdat`  in  NREQ*16  write data.
- `req_ack`  out  NREQ  one-cycle pulse: request latched.
- `rsp_valid`  out  NREQ  one-cycle completion pulse.
- `rsp_err`  out  NREQ  qualifies `rsp_valid`: failed.
- `rsp_rdat`  out  16  read data, shared; valid with any `rsp_valid`.
- `m_adr`, `m_dat`, `m_reg`  out  32/16/1  to controller `adr_i`, `dat_i`, `reg_space_i`.
- `m_rrq`, `m_wrq`  out  1  to controller `rrq`, `wrq`.
- `m_dat_o`, `m_dvalid`, `m_dready`, `m_busy`, `m_error`  in  16/1/1/1/1  from controller.
- `fault_o`  out  1  sticky fault.

## Operation
- States: IDLE, ISSUE, ACTIVE, DRAIN, FAULT.
- IDLE: if any `req_valid` and `m_busy`=0, the winner is chosen by rotating priority starting at `last+1` (wrap to 0). The winner's fields are registered into `m_*`, `req_ack[w]` pulses, `last`<=w, `m_rrq`=~we or `m_wrq`=we, and the state goes to ISSUE. The watchdog loads TIMEOUT.
- ISSUE: command held. `m_busy`=1 -> ACTIVE.
- ACTIVE: command held, because the controller re-samples `m_rrq` after latency.
  - Read: first `m_dvalid` -> `rsp_valid[w]`=1, `rsp_rdat`<=`m_dat_o`.
  - Write: first `m_dready` -> `rsp_valid[w]`=1.
  - In either case, drop `m_rrq`/`m_wrq` and go to DRAIN.
- DRAIN: `m_busy`=0 -> IDLE. No new grant is issued in the same cycle.
- `m_error`=1 in ISSUE/ACTIVE/DRAIN: `rsp_valid[w]`=`rsp_err[w]`=1, command dropped, go to FAULT.
- Watchdog reaching 0 in ISSUE/ACTIVE/DRAIN: same as `m_error`.
- FAULT: `fault_o`=1. Exit only by reset. Any `req_valid[i]` gets `req_ack[i]` and, one cycle later, `rsp_valid[i]`+`rsp_err[i]`. Round-robin is still applied, one port per two cycles.
- Only one transaction is outstanding. Non-granted ports wait with `req_valid` held; no starvation, with bound (NREQ-1) transactions.
- Address is passed unchanged (32 b); data width is fixed at 16 (controller WIDTH=8).

## Timing
- All outputs are registered.
- Reset values:
  - `req_ack`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_rdat`, `m_adr`, `m_dat` = 0.
  - `m_reg`, `m_rrq`, `m_wrq` = 0.
  - `fault_o` = 0.
  - `last` = NREQ-1, so port 0 wins first.
  - state = IDLE.
- Grant latency: `req_valid` seen in IDLE at edge N -> `req_ack` and `m_rrq`/`m_wrq` high after edge N.
- Response: `rsp_valid` follows `m_dvalid`/`m_dready` by one cycle. The command deasserts on the same edge.
- IDLE is not re-entered until `m_busy` is observed low. Minimum spacing between `req_ack` pulses is 4 cycles.
- Simultaneous `m_error` and `m_dvalid`: error wins (`rsp_err`=1).
- Requester dropping `req_valid` before ack is illegal. The arbiter samples only in IDLE.
- `rstn` asserted mid-transaction clears everything immediately. The controller is reset by the same source.

## Structure
- `hyperbus_pkg`: state encodings (one-hot, 5 bits), DATA_W=16, ADR_W=32, default TIMEOUT.
- Sub-module `hyperbus_rr_pick`: combinational rotating-priority picker (inputs `req`, `last`; outputs `grant` index and `any`).
- The top module holds the FSM, the field registers, the watchdog (`$clog2(TIMEOUT+1)` bits) and the response routing.

## Test plan
- Single read, port 0, adr 0x0000_0010. The controller model returns `m_dat_o`=0xA55A.
  - `req_ack`=2'b01 and `m_rrq`=1 one cycle after `req_valid`.
  - `rsp_valid`=2'b01 with `rsp_rdat`=0xA55A.
  - `m_rrq` low before `m_busy` falls.
- Both ports request reads continuously, 6 transactions: grant order 0,1,0,1,0,1. Each ack is ≥4 cycles after the previous one.
- Port 1 write, `req_wdat`=0x1234, `req_reg`=1:
  - `m_wrq`=1, `m_reg`=1, `m_dat`=0x1234.
  - `rsp_valid`=2'b10 one cycle after `m_dready`.
- Controller model raises `m_error` during ACTIVE on port 0:
  - `rsp_err[0]`=1 and `fault_o`=1.
  - A later request from port 1 gets ack, then `rsp_err[1]`=1 one cycle later, and `m_rrq` stays 0.
- TIMEOUT=20 with the model never asserting `m_busy`: the fault fires exactly 20 cycles after ack.
- `rstn` low mid-ACTIVE: all outputs 0 immediately. After release, port 0 wins the next grant.
